// File: rtl/uart_block_assembler.sv
// Packs UART receiver bytes into 128-bit AES key / plaintext blocks.
// Partial blocks are dropped on clr, on an inter-byte timeout, or on a key_sel change.
module uart_block_assembler #(
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd5_000_000,
  parameter int          BYTES_PER_BLOCK = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [7:0]   RxData,
  input  logic         RxDone,
  input  logic         key_sel,
  input  logic         clr,
  output logic [127:0] key_out,
  output logic [127:0] data_out,
  output logic         key_valid,
  output logic         data_valid,
  output logic [3:0]   byte_cnt,
  output logic         busy,
  output logic         timeout_err,
  output logic         sel_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLOCK - 1);

  state_t         state_q, state_d;
  logic           rxdone_q;
  logic           accept;
  // Only the 15 most recent bytes are kept; the 16th arrives on RxData.
  logic [119:0]   shift_q, shift_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic           target_q, target_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    timer_q, timer_d;
  logic           key_vld_q, key_vld_d;
  logic           data_vld_q, data_vld_d;
  logic           terr_q, terr_d;
  logic           serr_q, serr_d;
  logic           timeout_hit;

  assign accept      = RxDone & ~rxdone_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (timer_q == (TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      rxdone_q   <= 1'b0;
      shift_q    <= '0;
      key_q      <= '0;
      data_q     <= '0;
      target_q   <= 1'b0;
      cnt_q      <= '0;
      timer_q    <= '0;
      key_vld_q  <= 1'b0;
      data_vld_q <= 1'b0;
      terr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxdone_q   <= RxDone;
      shift_q    <= shift_d;
      key_q      <= key_d;
      data_q     <= data_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      key_vld_q  <= key_vld_d;
      data_vld_q <= data_vld_d;
      terr_q     <= terr_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    key_d      = key_q;
    data_d     = data_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    key_vld_d  = 1'b0;
    data_vld_d = 1'b0;
    terr_d     = 1'b0;
    serr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (accept) begin
          shift_d  = {shift_q[111:0], RxData};
          target_d = key_sel;
          cnt_d    = 4'd1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (clr) begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else if (accept) begin
          timer_d = '0;
          if (key_sel != target_q) begin
            // The byte that exposed the target change opens a fresh block.
            serr_d   = 1'b1;
            shift_d  = {112'd0, RxData};
            target_d = key_sel;
            cnt_d    = 4'd1;
          end else if (cnt_q == LAST_IDX) begin
            if (target_q) begin
              key_d     = {shift_q, RxData};
              key_vld_d = 1'b1;
            end else begin
              data_d     = {shift_q, RxData};
              data_vld_d = 1'b1;
            end
            shift_d = {shift_q[111:0], RxData};
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            shift_d = {shift_q[111:0], RxData};
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (timeout_hit) begin
          terr_d  = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_out     = key_q;
  assign data_out    = data_q;
  assign key_valid   = key_vld_q;
  assign data_valid  = data_vld_q;
  assign byte_cnt    = cnt_q;
  assign busy        = (state_q == COLLECT);
  assign timeout_err = terr_q;
  assign sel_err     = serr_q;

endmodule

// File: doc/uart_block_assembler.md
Name: uart_block_assembler

Overview:
Packs the byte stream from the UART receiver into 128-bit AES operands. It sits between the UART byte receiver and the AES cipher. Each group of 16 received bytes is steered into either the key register or the plaintext register, and a one-cycle valid strobe is raised when a complete block lands. Partial blocks are discarded, and an error is flagged, on an inter-byte timeout or when the target changes mid-block.

Parameters:
TIMEOUT_CYCLES, 32'd5_000_000, max Clk cycles allowed between accepted bytes inside a block; 0 disables the timeout
BYTES_PER_BLOCK, 16, bytes per block; fixed at 16; any other value is unsupported

Ports:
Clk  input  1  system clock; the only clock
Rst_n  input  1  asynchronous, active-low reset
RxData  input  8  received byte; valid while RxDone is high
RxDone  input  1  receiver done flag, synchronous to Clk; may stay high for several cycles
key_sel  input  1  1 = current/next block is the key; 0 = plaintext
clr  input  1  synchronous abort of any partial block
key_out  output  128  last completed key block
data_out  output  128  last completed plaintext block
key_valid  output  1  one-cycle pulse: key_out updated
data_valid  output  1  one-cycle pulse: data_out updated
byte_cnt  output  4  bytes held in the current partial block (0-15)
busy  output  1  high while in COLLECT
timeout_err  output  1  one-cycle pulse: partial block dropped on timeout
sel_err  output  1  one-cycle pulse: partial block dropped on key_sel change

Behaviour:
- Reset (Rst_n=0, asynchronous): every output, shift_reg, target, the timer and rxdone_q go to 0; state = IDLE.
- Byte accept = RxDone & ~rxdone_q, where rxdone_q is RxDone registered. Only one accept happens per RxDone high period.
- Shift on accept: shift_reg <= {shift_reg[119:0], RxData}. The first byte of a block ends in bits [127:120].
- IDLE state:
  - On accept: latch target <= key_sel, byte_cnt <= 1, go to COLLECT.
- COLLECT state, priority order:
  - clr: drop the partial block, byte_cnt <= 0, go to IDLE. No error pulse.
  - Accept with key_sel != target: pulse sel_err. The current byte starts a new block: shift_reg holds only this byte, target <= key_sel, byte_cnt <= 1.
  - Accept with byte_cnt == 15:
    - Copy {shift_reg[119:0], RxData} into key_out (target=1) or data_out (target=0).
    - The matching valid signal is high for exactly the next cycle (latency 1 Clk after the accept edge).
    - byte_cnt <= 0, go to IDLE.
  - Accept otherwise: byte_cnt increments.
  - No accept: the timer increments; it is cleared on every accept.
  - Timer reaches TIMEOUT_CYCLES (when nonzero): pulse timeout_err, byte_cnt <= 0, go to IDLE.
- clr in IDLE has no effect. clr has priority over an accept in the same cycle, so that byte is dropped.
- key_out and data_out change only on block completion; they hold their value otherwise, including through clr and error events.
- busy = (state == COLLECT).
- The valid and error pulses are never asserted together.
- key_sel is sampled only on accept cycles.

Test Plan:
1. Reset, key_sel=1, send bytes 0x00..0x0F. Required: key_out = 128'h000102030405060708090A0B0C0D0E0F; key_valid high for exactly 1 cycle, 1 Clk after the 16th accept; data_out = 0; byte_cnt returns to 0.
2. key_sel=0, send 16 bytes of 0x11. Required: data_out = {16{8'h11}}; data_valid pulse; key_out unchanged from scenario 1.
3. Hold RxDone high for 5 cycles per byte and send 16 bytes 0xA5. Required: exactly 16 accepts; one data_valid; data_out = {16{8'hA5}}.
4. TIMEOUT_CYCLES=100. Send 5 bytes, then idle 100 cycles. Required: timeout_err pulse; byte_cnt = 0; no valid pulse. A following 16 bytes still completes correctly.
5. key_sel=0, send 7 bytes; set key_sel=1 and send 16 bytes 0xFF. Required: sel_err pulse on the 8th accept; key_valid after 16 more bytes with key_out = all-ones; data_out unchanged.
6. Send 9 bytes, then deassert Rst_n mid-block and release. Required: all outputs 0 immediately; the next 16 bytes form a clean block. Repeat with clr after 9 bytes: byte_cnt = 0, no error pulse.
